// File: rtl/leb128_pkg.sv
// Shared types and helpers for the streaming LEB128 decoder.
package leb128_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } leb128_state_e;

    localparam bit LEB128_UNSIGNED = 1'b0;
    localparam bit LEB128_SIGNED   = 1'b1;

    // Encoded bytes needed to carry a width-bit value (7 payload bits per byte).
    function automatic int unsigned leb128_max_bytes(input int unsigned width);
        return (width + 32'd6) / 32'd7;
    endfunction

endpackage

// File: rtl/leb128_byte_merge.sv
// Merges one LEB128 byte into the running accumulator and builds the terminated value.
// Optional malformed-encoding detection is enabled by defining LEB128_CHECK_EN.
module leb128_byte_merge
    import leb128_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = LEB128_SIGNED,
    localparam int unsigned MAXB  = leb128_max_bytes(WIDTH),
    localparam int unsigned CW    = $clog2(MAXB + 1)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [7:0]       byte_i,
    input  logic [CW-1:0]    cnt_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] result_o,
    output logic             last_o,
    output logic             err_o
);

    localparam int unsigned SW = $clog2(7 * MAXB + 8);

    logic [6:0]       payload;
    logic [SW-1:0]    sh_lo;
    logic [SW-1:0]    sh_hi;
    logic [WIDTH-1:0] ext_mask;
    logic             at_max;

    // Shifts past WIDTH yield zero, which gives both truncation and the "no fill" case.
    always_comb begin
        payload  = byte_i[6:0];
        sh_lo    = SW'(cnt_i) * SW'(7);
        sh_hi    = sh_lo + SW'(7);
        ext_mask = {WIDTH{1'b1}} << sh_hi;
        acc_o    = acc_i | (WIDTH'(payload) << sh_lo);
        result_o = acc_o | ((SIGNED && payload[6]) ? ext_mask : '0);
        at_max   = (cnt_i == CW'(MAXB - 1));
        last_o   = !byte_i[7] || at_max;
    end

`ifdef LEB128_CHECK_EN
    localparam int unsigned USED = WIDTH - 7 * (MAXB - 1);

    logic fill;
    logic bad_hi;

    // Payload bits above the value width must repeat the fill (zero or sign).
    always_comb begin
        fill   = SIGNED ? payload[USED-1] : 1'b0;
        bad_hi = 1'b0;
        for (int unsigned i = USED; i < 7; i++) begin
            if (payload[i] != fill) begin
                bad_hi = 1'b1;
            end
        end
        err_o = at_max && (byte_i[7] || bad_hi);
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/leb128_stream_decoder.sv
// Streaming LEB128 decoder: one byte in per cycle, one WIDTH-bit value out per group.
// Define LEB128_CHECK_EN to flag over-long or overflowing encodings on out_error.
module leb128_stream_decoder
    import leb128_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = LEB128_SIGNED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_error
);

    localparam int unsigned MAXB = leb128_max_bytes(WIDTH);
    localparam int unsigned CW   = $clog2(MAXB + 1);

    leb128_state_e    state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_error_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] result;
    logic             last;
    logic             err;
    logic             accept;

    leb128_byte_merge #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_merge (
        .acc_i    (acc_q),
        .byte_i   (in_data),
        .cnt_i    (cnt_q),
        .acc_o    (acc_d),
        .result_o (result),
        .last_o   (last),
        .err_o    (err)
    );

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_error = out_error_q;

    // Handshake FSM with byte counter, accumulator and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_error_q <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    out_data_q  <= result;
                    out_error_q <= err;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            case (state_q)
                ACC: begin
                    if (accept && last) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready && !(accept && last)) begin
                        state_q <= ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Bench for leb128_stream_decoder: three configurations share one byte stream.
// Compile with LEB128_CHECK_EN defined to also exercise out_error.
module tb_leb128_stream_decoder;

`ifdef LEB128_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } exp_t;

    typedef struct packed {
        logic [39:0] bytes;
        logic [3:0]  n;
        logic [63:0] e32s;
        logic [63:0] e32u;
        logic [63:0] e64s;
        logic        r32s;
        logic        r32u;
        logic        r64s;
    } vec_t;

    int W_T[3]    = '{32, 32, 64};
    bit SGN_T[3]  = '{1'b1, 1'b0, 1'b1};
    int MAXB_T[3] = '{5, 5, 10};

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic        all_ready;
    logic        in_valid_eff;

    logic [31:0] d32s, d32u;
    logic [63:0] d64s;
    logic [63:0] dd[3];
    logic        dv[3], de[3], dr[3];

    int checks = 0;
    int fails  = 0;
    bit took;
    bit rst_done;
    bit rand_ready;
    bit   hold[3];
    exp_t hold_v[3];

    logic [7:0] pend[3][$];
    exp_t       exp_q[3][$];
    vec_t       tbl[$];

    always #5 clk = ~clk;

    assign all_ready    = dr[0] && dr[1] && dr[2];
    assign in_valid_eff = in_valid && all_ready;
    assign dd[0] = 64'(d32s);
    assign dd[1] = 64'(d32u);
    assign dd[2] = d64s;

    leb128_stream_decoder #(.WIDTH(32), .SIGNED(1'b1)) u_32s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_eff),
        .in_ready(dr[0]), .out_data(d32s), .out_valid(dv[0]), .out_ready(out_ready),
        .out_error(de[0]));
    leb128_stream_decoder #(.WIDTH(32), .SIGNED(1'b0)) u_32u (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_eff),
        .in_ready(dr[1]), .out_data(d32u), .out_valid(dv[1]), .out_ready(out_ready),
        .out_error(de[1]));
    leb128_stream_decoder #(.WIDTH(64), .SIGNED(1'b1)) u_64s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_eff),
        .in_ready(dr[2]), .out_data(d64s), .out_valid(dv[2]), .out_ready(out_ready),
        .out_error(de[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = sum(payload_i * 128^i), sign-extended from the last payload bit 6.
    task automatic model_push(input logic [7:0] b);
        logic [79:0] v, hi, ones;
        logic [7:0]  pb;
        int          n;
        bit          fits;
        exp_t        e;
        for (int k = 0; k < 3; k++) begin
            pend[k].push_back(b);
            n = pend[k].size();
            if (!b[7] || n == MAXB_T[k]) begin
                v = '0;
                for (int i = 0; i < n; i++) begin
                    pb = pend[k][i];
                    v  = v | (80'(pb[6:0]) << (7 * i));
                end
                if (SGN_T[k] && b[6]) v = v - (80'(1) << (7 * n));
                hi   = v >> (W_T[k] - 1);
                ones = ~80'(0) >> (W_T[k] - 1);
                fits = SGN_T[k] ? (hi == '0 || hi == ones) : ((v >> W_T[k]) == '0);
                e.d  = (W_T[k] == 64) ? v[63:0] : {32'h0, v[31:0]};
                e.e  = CHECK_EN && ((b[7] && n == MAXB_T[k]) || !fits);
                exp_q[k].push_back(e);
                pend[k].delete();
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            pend[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rst_done) begin
                chk($sformatf("reset_valid[%0d]", k), 64'(dv[k]), 64'd0);
                chk($sformatf("reset_data[%0d]", k), dd[k], 64'd0);
                chk($sformatf("reset_err[%0d]", k), 64'(de[k]), 64'd0);
                hold[k] = 1'b0;
            end else begin
                if (hold[k]) begin
                    chk($sformatf("stall_valid[%0d]", k), 64'(dv[k]), 64'd1);
                    chk($sformatf("stall_data[%0d]", k), dd[k], hold_v[k].d);
                    chk($sformatf("stall_err[%0d]", k), 64'(de[k]), 64'(hold_v[k].e));
                end
                if (dv[k] && out_ready && !reset) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_output[%0d]: got %h expected none", k, dd[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("model_data[%0d]", k), dd[k], e.d);
                        chk($sformatf("model_err[%0d]", k), 64'(de[k]), 64'(e.e));
                    end
                end
                hold[k]     = dv[k] && !out_ready && !reset;
                hold_v[k].d = dd[k];
                hold_v[k].e = de[k];
            end
        end
    endtask

    // One clock: check at the falling edge, update the model just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        took = in_valid && all_ready && !reset;
        @(posedge clk);
        rst_done = reset;
        #1;
        if (rst_done) model_clear();
        else if (took) model_push(in_data);
        if (rand_ready) out_ready = ($urandom % 4) != 0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        took     = 1'b0;
        while (!took && waited < 100) begin
            cycle();
            waited++;
        end
        if (!took) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept of %h", b);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic add_vec(input logic [39:0] bytes, input int n, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c, input logic [2:0] r);
        vec_t v;
        v.bytes = bytes; v.n = 4'(n);
        v.e32s = a; v.e32u = b; v.e64s = c;
        v.r32s = r[2]; v.r32u = r[1]; v.r64s = r[0];
        tbl.push_back(v);
    endtask

    initial begin
        int          w;
        vec_t        v;
        logic [7:0]  b;
        logic [63:0] ev[3];
        logic        er[3];

        add_vec(40'h59F19B, 3, 64'hFFF6789B, 64'h0016789B, 64'hFFFFFFFFFFF6789B, 3'b000);
        add_vec(40'h268EE5, 3, 64'h00098765, 64'h00098765, 64'h0000000000098765, 3'b000);
        add_vec(40'h00,     1, 64'h0,        64'h0,        64'h0,                3'b000);
        add_vec(40'h7F,     1, 64'hFFFFFFFF, 64'h0000007F, 64'hFFFFFFFFFFFFFFFF, 3'b000);
        add_vec(40'h0FFFFFFFFF, 5, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000FFFFFFFF, 3'b100);
        add_vec(40'h1FFFFFFFFF, 5, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001FFFFFFFF, 3'b110);
        add_vec(40'h40,     1, 64'hFFFFFFC0, 64'h00000040, 64'hFFFFFFFFFFFFFFC0, 3'b000);

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; rand_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_reset_valid[%0d]", k), 64'(dv[k]), 64'd0);
            chk($sformatf("post_reset_ready[%0d]", k), 64'(dr[k]), 64'd1);
        end

        // Table: each entry terminates exactly one value in every configuration.
        foreach (tbl[t]) begin
            v = tbl[t];
            ev[0] = v.e32s; ev[1] = v.e32u; ev[2] = v.e64s;
            er[0] = v.r32s; er[1] = v.r32u; er[2] = v.r64s;
            for (int i = 0; i < int'(v.n); i++) begin
                send_byte(v.bytes[8*i +: 8], w);
                if (i < int'(v.n) - 1)
                    for (int k = 0; k < 3; k++)
                        chk($sformatf("vec%0d_early_valid[%0d]", t, k), 64'(dv[k]), 64'd0);
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("vec%0d_valid[%0d]", t, k), 64'(dv[k]), 64'd1);
                chk($sformatf("vec%0d_data[%0d]", t, k), dd[k], ev[k]);
                chk($sformatf("vec%0d_err[%0d]", t, k), 64'(de[k]), 64'(er[k] && CHECK_EN));
            end
        end
        idle(2);

        // Back-to-back: a single-byte zero right after a 3-byte value, no bubble.
        send_byte(8'hE5, w); send_byte(8'h8E, w); send_byte(8'h26, w);
        chk("b2b_first", dd[1], 64'h00098765);
        send_byte(8'h00, w);
        chk("b2b_wait", 64'(w), 64'd1);
        chk("b2b_valid", 64'(dv[1]), 64'd1);
        chk("b2b_zero", dd[1], 64'd0);
        idle(2);

        // Output stall: value held, input blocked, then released.
        out_ready = 1'b0;
        send_byte(8'h7F, w);
        in_valid = 1'b0;
        repeat (5) begin
            cycle();
            chk("stall_hold_valid", 64'(dv[0]), 64'd1);
            chk("stall_hold_data", dd[0], 64'hFFFFFFFF);
            chk("stall_in_ready", 64'(dr[0]), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("release_in_ready", 64'(dr[0]), 64'd1);
        chk("release_valid", 64'(dv[0]), 64'd0);

        // Forced termination at the fifth byte, then resync.
        repeat (5) send_byte(8'h80, w);
        chk("force_data", dd[1], 64'd0);
        chk("force_err", 64'(de[1]), 64'(CHECK_EN));
        send_byte(8'h01, w);
        chk("resync_data", dd[1], 64'd1);
        chk("resync_err", 64'(de[1]), 64'd0);
        send_byte(8'h00, w);
        idle(2);

        // Reset mid-value discards partial bytes, and dominates a presented byte.
        send_byte(8'h80, w); send_byte(8'h80, w);
        in_data = 8'h05;
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        in_valid = 1'b0;
        cycle();
        send_byte(8'h05, w);
        for (int k = 0; k < 3; k++) chk($sformatf("after_reset_data[%0d]", k), dd[k], 64'd5);
        idle(2);

        // 64-bit signed: ten bytes with the top payload bit landing in bit 63.
        repeat (9) send_byte(8'h80, w);
        send_byte(8'h7F, w);
        chk("w64_data", dd[2], 64'h8000000000000000);
        chk("w64_err", 64'(de[2]), 64'd0);
        chk("w64_valid", 64'(dv[2]), 64'd1);
        idle(2);

        // Random bytes under random backpressure against the reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            b = 8'($urandom);
            b[7] = ($urandom % 4) != 0;
            if ($urandom % 6 == 0) idle(1);
            send_byte(b, w);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        send_byte(8'h00, w);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain_expected[%0d]", k), 64'(exp_q[k].size()), 64'd0);
            chk($sformatf("drain_partial[%0d]", k), 64'(pend[k].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
